mul_div_unit: RTL and testbench

MUL_DIV_UNIT -- requirements
Module: mul_div_unit

---
 rtl/mul_div_unit.sv | 127 ++++++++++++
 tb/tb_mul_div_unit.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/mul_div_unit.sv
// Multi-cycle multiply/divide unit with architectural HI/LO registers.
// Results are computed at issue and held pending until the busy countdown expires.
module mul_div_unit #(
    parameter int unsigned MULT_CYCLES = 5,
    parameter int unsigned DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [3:0]  MDU_op,
    input  logic [31:0] srcA,
    input  logic [31:0] srcB,
    input  logic        req,
    output logic        busy,
    output logic [31:0] result,
    output logic [31:0] HI_out,
    output logic [31:0] LO_out
);

    localparam logic [3:0] OP_MULT  = 4'd1;
    localparam logic [3:0] OP_MULTU = 4'd2;
    localparam logic [3:0] OP_DIV   = 4'd3;
    localparam logic [3:0] OP_DIVU  = 4'd4;
    localparam logic [3:0] OP_MFHI  = 4'd5;
    localparam logic [3:0] OP_MFLO  = 4'd6;
    localparam logic [3:0] OP_MTHI  = 4'd7;
    localparam logic [3:0] OP_MTLO  = 4'd8;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    logic [31:0] r_hi, r_lo, r_pend_hi, r_pend_lo;
    logic        r_pend_wr, r_busy;
    logic [4:0]  r_cnt;

    logic [63:0] w_prod_s, w_prod_u;
    logic        w_a_neg, w_b_neg, w_b_zero;
    logic [31:0] w_a_mag, w_b_mag, w_b_div;
    logic [31:0] w_q_mag, w_r_mag, w_q_s, w_r_s, w_q_u, w_r_u;

    // Low 64 bits of the sign-extended product equal the signed 64-bit product.
    assign w_prod_s = {{32{srcA[31]}}, srcA} * {{32{srcB[31]}}, srcB};
    assign w_prod_u = {32'd0, srcA} * {32'd0, srcB};

    // Signed divide via magnitudes so 0x80000000 / -1 wraps to 0x80000000 cleanly.
    assign w_b_zero = (srcB == 32'd0);
    assign w_a_neg  = srcA[31];
    assign w_b_neg  = srcB[31];
    assign w_a_mag  = w_a_neg ? (32'd0 - srcA) : srcA;
    assign w_b_mag  = w_b_zero ? 32'd1 : (w_b_neg ? (32'd0 - srcB) : srcB);
    assign w_q_mag  = w_a_mag / w_b_mag;
    assign w_r_mag  = w_a_mag % w_b_mag;
    assign w_q_s    = (w_a_neg ^ w_b_neg) ? (32'd0 - w_q_mag) : w_q_mag;
    assign w_r_s    = w_a_neg ? (32'd0 - w_r_mag) : w_r_mag;

    assign w_b_div  = w_b_zero ? 32'd1 : srcB;
    assign w_q_u    = srcA / w_b_div;
    assign w_r_u    = srcA % w_b_div;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hi      <= 32'd0;
            r_lo      <= 32'd0;
            r_pend_hi <= 32'd0;
            r_pend_lo <= 32'd0;
            r_pend_wr <= 1'b0;
            r_busy    <= 1'b0;
            r_cnt     <= 5'd0;
        end else if (r_busy) begin
            r_cnt <= r_cnt - 5'd1;
            if (r_cnt == 5'd1) begin
                r_busy <= 1'b0;
                if (r_pend_wr) begin
                    r_hi <= r_pend_hi;
                    r_lo <= r_pend_lo;
                end
            end
        end else if (!req) begin
            case (MDU_op)
                OP_MULT: begin
                    r_pend_hi <= w_prod_s[63:32];
                    r_pend_lo <= w_prod_s[31:0];
                    r_pend_wr <= 1'b1;
                    r_cnt     <= MULT_LOAD;
                    r_busy    <= 1'b1;
                end
                OP_MULTU: begin
                    r_pend_hi <= w_prod_u[63:32];
                    r_pend_lo <= w_prod_u[31:0];
                    r_pend_wr <= 1'b1;
                    r_cnt     <= MULT_LOAD;
                    r_busy    <= 1'b1;
                end
                OP_DIV: begin
                    r_pend_hi <= w_r_s;
                    r_pend_lo <= w_q_s;
                    r_pend_wr <= !w_b_zero;
                    r_cnt     <= DIV_LOAD;
                    r_busy    <= 1'b1;
                end
                OP_DIVU: begin
                    r_pend_hi <= w_r_u;
                    r_pend_lo <= w_q_u;
                    r_pend_wr <= !w_b_zero;
                    r_cnt     <= DIV_LOAD;
                    r_busy    <= 1'b1;
                end
                OP_MTHI: r_hi <= srcA;
                OP_MTLO: r_lo <= srcA;
                default: ;
            endcase
        end
    end

    always_comb begin
        result = 32'd0;
        if (MDU_op == OP_MFHI) begin
            result = r_hi;
        end else if (MDU_op == OP_MFLO) begin
            result = r_lo;
        end
    end

    assign busy   = r_busy;
    assign HI_out = r_hi;
    assign LO_out = r_lo;

endmodule

// File: tb/tb_mul_div_unit.sv
// Random and directed checks of mul_div_unit against a cycle-level arithmetic model.
module tb_mul_div_unit;

    localparam int MC = 5;
    localparam int DC = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [3:0]  MDU_op = 4'd0;
    logic [31:0] srcA = 32'd0;
    logic [31:0] srcB = 32'd0;
    logic        req = 1'b0;
    logic        busy;
    logic [31:0] result, HI_out, LO_out;

    int n_checks = 0;
    int n_fail = 0;

    // Model state
    logic [31:0] m_hi, m_lo, m_phi, m_plo;
    logic        m_busy, m_wr;
    int          m_left;

    mul_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
        .clk    (clk),
        .reset  (reset),
        .MDU_op (MDU_op),
        .srcA   (srcA),
        .srcB   (srcB),
        .req    (req),
        .busy   (busy),
        .result (result),
        .HI_out (HI_out),
        .LO_out (LO_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_hi = 0; m_lo = 0; m_phi = 0; m_plo = 0;
        m_busy = 0; m_wr = 0; m_left = 0;
    endtask

    task automatic model_step(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic rq);
        longint      sa, sb, q, r;
        logic [63:0] p;
        if (m_busy) begin
            m_left--;
            if (m_left == 0) begin
                m_busy = 0;
                if (m_wr) begin
                    m_hi = m_phi;
                    m_lo = m_plo;
                end
            end
        end else if (!rq) begin
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            case (op)
                4'd1: begin
                    p = 64'(sa * sb);
                    m_phi = p[63:32]; m_plo = p[31:0]; m_wr = 1;
                    m_busy = 1; m_left = MC;
                end
                4'd2: begin
                    p = {32'd0, a} * {32'd0, b};
                    m_phi = p[63:32]; m_plo = p[31:0]; m_wr = 1;
                    m_busy = 1; m_left = MC;
                end
                4'd3: begin
                    m_wr = (b != 0);
                    if (b != 0) begin
                        q = sa / sb;
                        r = sa % sb;
                        m_plo = q[31:0]; m_phi = r[31:0];
                    end
                    m_busy = 1; m_left = DC;
                end
                4'd4: begin
                    m_wr = (b != 0);
                    if (b != 0) begin
                        m_plo = a / b; m_phi = a % b;
                    end
                    m_busy = 1; m_left = DC;
                end
                4'd7: m_hi = a;
                4'd8: m_lo = a;
                default: ;
            endcase
        end
    endtask

    // One clock cycle: drive, compare at negedge, advance model, pass posedge.
    task automatic cycle(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic rq, output logic busy_s);
        logic [31:0] exp_res;
        MDU_op = op; srcA = a; srcB = b; req = rq;
        @(negedge clk);
        exp_res = (op == 4'd5) ? m_hi : (op == 4'd6) ? m_lo : 32'd0;
        check("busy", {31'd0, busy}, {31'd0, m_busy});
        check("hi", HI_out, m_hi);
        check("lo", LO_out, m_lo);
        check("result", result, exp_res);
        busy_s = busy;
        model_step(op, a, b, rq);
        @(posedge clk);
        #1;
    endtask

    task automatic count_busy(output int n);
        logic b;
        n = 0;
        for (int i = 0; i < 40; i++) begin
            cycle(4'd0, 32'd0, 32'd0, 1'b0, b);
            if (!b) break;
            n++;
        end
    endtask

    function automatic logic [31:0] rand_operand();
        case ($urandom_range(0, 7))
            0: return 32'd0;
            1: return 32'h8000_0000;
            2: return 32'hFFFF_FFFF;
            3: return 32'($urandom_range(0, 20));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic b;
        int   n;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check("reset_busy", {31'd0, busy}, 32'd0);
        check("reset_hi", HI_out, 32'd0);
        check("reset_lo", LO_out, 32'd0);
        reset = 1'b0;

        cycle(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b0, b);
        count_busy(n);
        check("mult_busy_len", 32'(n), 32'd5);
        check("mult_hi", HI_out, 32'hFFFF_FFFF);
        check("mult_lo", LO_out, 32'hFFFF_FFFA);

        cycle(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, b);
        count_busy(n);
        check("multu_hi", HI_out, 32'hFFFF_FFFE);
        check("multu_lo", LO_out, 32'h0000_0001);
        MDU_op = 4'd6;
        #1;
        check("mflo_result", result, 32'h0000_0001);
        MDU_op = 4'd11;
        #1;
        check("op11_result", result, 32'd0);

        cycle(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b0, b);
        count_busy(n);
        check("div_busy_len", 32'(n), 32'd10);
        check("div_lo", LO_out, 32'hFFFF_FFFD);
        check("div_hi", HI_out, 32'hFFFF_FFFF);

        cycle(4'd4, 32'd100, 32'd7, 1'b0, b);
        count_busy(n);
        check("divu_lo", LO_out, 32'd14);
        check("divu_hi", HI_out, 32'd2);
        cycle(4'd4, 32'h1234_5678, 32'd0, 1'b0, b);
        count_busy(n);
        check("div0_busy_len", 32'(n), 32'd10);
        check("div0_hi", HI_out, 32'd2);
        check("div0_lo", LO_out, 32'd14);

        cycle(4'd7, 32'h1234, 32'd0, 1'b1, b);
        check("mthi_req_hi", HI_out, 32'd2);
        cycle(4'd1, 32'd6, 32'd7, 1'b0, b);
        cycle(4'd8, 32'hDEAD, 32'd0, 1'b0, b);
        count_busy(n);
        check("mult_intact_hi", HI_out, 32'd0);
        check("mult_intact_lo", LO_out, 32'd42);

        cycle(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, b);
        count_busy(n);
        check("div_ovf_lo", LO_out, 32'h8000_0000);
        check("div_ovf_hi", HI_out, 32'd0);

        // Back-to-back: op held high across the busy fall
        for (int i = 0; i < 14; i++) cycle(4'd2, 32'd3 + 32'(i), 32'd5, 1'b0, b);

        // Abort a divide during its third busy cycle
        count_busy(n);
        cycle(4'd4, 32'd1000, 32'd3, 1'b0, b);
        cycle(4'd0, 32'd0, 32'd0, 1'b0, b);
        cycle(4'd0, 32'd0, 32'd0, 1'b0, b);
        #2 reset = 1'b1;
        #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_hi", HI_out, 32'd0);
        check("abort_lo", LO_out, 32'd0);
        model_reset();
        #2 reset = 1'b0;
        for (int i = 0; i < 15; i++) cycle(4'd0, 32'd0, 32'd0, 1'b0, b);
        cycle(4'd1, 32'd9, 32'd9, 1'b0, b);
        count_busy(n);
        check("post_reset_lo", LO_out, 32'd81);

        for (int i = 0; i < 3000; i++) begin
            logic [3:0] op;
            op = ($urandom_range(0, 9) < 8) ? 4'($urandom_range(0, 8)) : 4'($urandom_range(9, 15));
            cycle(op, rand_operand(), rand_operand(), ($urandom_range(0, 7) == 0), b);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
